// File: rtl/spi_cfg_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : spi_cfg_pkg
//  Description : Shared types and constants for the SPI configuration
//                sequencer and its frame shifter.
//  Revision    : 1.0 - initial release
// ============================================================================
package spi_cfg_pkg;

    // Sequencer states
    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_FETCH    = 4'd1,
        S_WR_SHIFT = 4'd2,
        S_RD_CMD   = 4'd3,
        S_RD_SHIFT = 4'd4,
        S_LATCH    = 4'd5,
        S_GAP      = 4'd6,
        S_CHECK    = 4'd7,
        S_NEXT     = 4'd8,
        S_DONE     = 4'd9,
        S_ERR      = 4'd10
    } state_e;

    // Kind of the frame most recently shifted
    typedef enum logic [1:0] {
        FR_WRITE = 2'd0,
        FR_RDCMD = 2'd1,
        FR_READ  = 2'd2
    } frame_e;

    localparam logic [3:0] RD_CMD_NIBBLE = 4'hE;
    localparam int         ADDR_W        = 4;

    // Ceiling log2, never less than 1 so that single-entry ranges still get a bit
    function automatic int clog2_min1(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                r = i + 1;
            end
        end
        if (r < 1) begin
            r = 1;
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/spi_cfg_sequencer_shifter.sv
`default_nettype none
// ============================================================================
//  Module      : spi_frame_shifter
//  Description : Shifts one DATA_W frame LSB-first with spi_le low, optionally
//                capturing miso on each spi_clk rising edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module spi_frame_shifter
    import spi_cfg_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int CLK_DIV = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              go_i,
    input  logic [DATA_W-1:0] tx_word_i,
    input  logic              rx_en_i,
    input  logic              miso_i,
    output logic              spi_clk_o,
    output logic              mosi_o,
    output logic              le_o,
    output logic [DATA_W-1:0] rx_word_o,
    output logic              frame_done_o
);

    localparam int               PH_W     = clog2_min1(2 * CLK_DIV);
    localparam int               BIT_W    = clog2_min1(DATA_W);
    localparam logic [PH_W-1:0]  PH_RISE  = PH_W'(CLK_DIV - 1);
    localparam logic [PH_W-1:0]  PH_LAST  = PH_W'(2 * CLK_DIV - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);

    logic              active_q;
    logic [PH_W-1:0]   ph_q;
    logic [BIT_W-1:0]  bit_q;
    logic [DATA_W-1:0] sr_q;
    logic [DATA_W-1:0] rx_q;
    logic              sclk_q;
    logic              le_q;
    logic              done_q;
    logic              rx_en_q;

    // mosi is the shift register LSB; the register is cleared between frames
    assign mosi_o       = sr_q[0];
    assign spi_clk_o    = sclk_q;
    assign le_o         = le_q;
    assign rx_word_o    = rx_q;
    assign frame_done_o = done_q;

    // Bit timing: spi_clk low for the first half of each bit, high for the second
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            active_q <= 1'b0;
            ph_q     <= '0;
            bit_q    <= '0;
            sr_q     <= '0;
            rx_q     <= '0;
            sclk_q   <= 1'b0;
            le_q     <= 1'b1;
            done_q   <= 1'b0;
            rx_en_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (!active_q) begin
                if (go_i) begin
                    active_q <= 1'b1;
                    ph_q     <= '0;
                    bit_q    <= '0;
                    sr_q     <= tx_word_i;
                    rx_q     <= '0;
                    sclk_q   <= 1'b0;
                    le_q     <= 1'b0;
                    rx_en_q  <= rx_en_i;
                end
            end else begin
                ph_q <= ph_q + PH_W'(1);
                if (ph_q == PH_RISE) begin
                    sclk_q <= 1'b1;
                    if (rx_en_q) begin
                        rx_q <= {miso_i, rx_q[DATA_W-1:1]};
                    end
                end
                if (ph_q == PH_LAST) begin
                    sclk_q <= 1'b0;
                    ph_q   <= '0;
                    if (bit_q == BIT_LAST) begin
                        active_q <= 1'b0;
                        le_q     <= 1'b1;
                        sr_q     <= '0;
                        done_q   <= 1'b1;
                    end else begin
                        bit_q <= bit_q + BIT_W'(1);
                        sr_q  <= {1'b0, sr_q[DATA_W-1:1]};
                    end
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/spi_cfg_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : spi_cfg_sequencer
//  Description : Walks a register table, writes each word over SPI, optionally
//                reads it back and retries mismatching writes.
//  Revision    : 1.0 - initial release
// ============================================================================
module spi_cfg_sequencer
    import spi_cfg_pkg::*;
#(
    parameter int NUM_REGS   = 11,
    parameter int DATA_W     = 32,
    parameter int CLK_DIV    = 4,
    parameter int LE_HOLD    = 4,
    parameter int GAP_CYCLES = 600,
    parameter int VERIFY     = 1,
    parameter int MAX_RETRY  = 2
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                start,
    output logic [clog2_min1(NUM_REGS)-1:0]     cfg_idx,
    input  logic [DATA_W-1:0]                   cfg_word,
    output logic                                spi_clk,
    output logic                                spi_mosi,
    input  logic                                spi_miso,
    output logic                                spi_le,
    output logic                                busy,
    output logic                                done,
    output logic                                error,
    output logic [clog2_min1(NUM_REGS)-1:0]     err_idx,
    output logic [DATA_W-1:0]                   rd_data
);

    localparam int IDX_W   = clog2_min1(NUM_REGS);
    localparam int RETRY_W = clog2_min1(MAX_RETRY + 1);
    localparam int CNT_MAX = (GAP_CYCLES > LE_HOLD) ? GAP_CYCLES : ((LE_HOLD > 2) ? LE_HOLD : 2);
    localparam int CNT_W   = clog2_min1(CNT_MAX + 1);

    localparam logic [CNT_W-1:0]   LE_LAST   = CNT_W'((LE_HOLD > 0) ? LE_HOLD - 1 : 0);
    localparam logic [CNT_W-1:0]   GAP_LAST  = CNT_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
    localparam logic [IDX_W-1:0]   IDX_LAST  = IDX_W'(NUM_REGS - 1);
    localparam logic [RETRY_W-1:0] RETRY_LIM = RETRY_W'(MAX_RETRY);

    state_e             state_q,   state_d;
    frame_e             kind_q,    kind_d;
    logic [IDX_W-1:0]   idx_q,     idx_d;
    logic [RETRY_W-1:0] retry_q,   retry_d;
    logic [CNT_W-1:0]   cnt_q,     cnt_d;
    logic [DATA_W-1:0]  wr_word_q, wr_word_d;
    logic [DATA_W-1:0]  tx_word_q, tx_word_d;
    logic               go_q,      go_d;
    logic               rx_en_q,   rx_en_d;
    logic               busy_q,    busy_d;
    logic               done_q,    done_d;
    logic               error_q,   error_d;
    logic [IDX_W-1:0]   err_idx_q, err_idx_d;
    logic [DATA_W-1:0]  rd_data_q, rd_data_d;

    logic               frame_done;
    logic [DATA_W-1:0]  rx_word;

    spi_frame_shifter #(
        .DATA_W  (DATA_W),
        .CLK_DIV (CLK_DIV)
    ) u_shifter (
        .clk          (clk),
        .rst          (rst),
        .go_i         (go_q),
        .tx_word_i    (tx_word_q),
        .rx_en_i      (rx_en_q),
        .miso_i       (spi_miso),
        .spi_clk_o    (spi_clk),
        .mosi_o       (spi_mosi),
        .le_o         (spi_le),
        .rx_word_o    (rx_word),
        .frame_done_o (frame_done)
    );

    assign cfg_idx = idx_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign error   = error_q;
    assign err_idx = err_idx_q;
    assign rd_data = rd_data_q;

    // State and datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            kind_q    <= FR_WRITE;
            idx_q     <= '0;
            retry_q   <= '0;
            cnt_q     <= '0;
            wr_word_q <= '0;
            tx_word_q <= '0;
            go_q      <= 1'b0;
            rx_en_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            error_q   <= 1'b0;
            err_idx_q <= '0;
            rd_data_q <= '0;
        end else begin
            state_q   <= state_d;
            kind_q    <= kind_d;
            idx_q     <= idx_d;
            retry_q   <= retry_d;
            cnt_q     <= cnt_d;
            wr_word_q <= wr_word_d;
            tx_word_q <= tx_word_d;
            go_q      <= go_d;
            rx_en_q   <= rx_en_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            error_q   <= error_d;
            err_idx_q <= err_idx_d;
            rd_data_q <= rd_data_d;
        end
    end

    // Sequencing: table fetch, frame launch, inter-frame timing, compare and retry
    always_comb begin
        state_d   = state_q;
        kind_d    = kind_q;
        idx_d     = idx_q;
        retry_d   = retry_q;
        cnt_d     = cnt_q;
        wr_word_d = wr_word_q;
        tx_word_d = tx_word_q;
        go_d      = 1'b0;
        rx_en_d   = rx_en_q;
        busy_d    = busy_q;
        done_d    = done_q;
        error_d   = error_q;
        err_idx_d = err_idx_q;
        rd_data_d = rd_data_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    done_d  = 1'b0;
                    error_d = 1'b0;
                    busy_d  = 1'b1;
                    idx_d   = '0;
                    retry_d = '0;
                    cnt_d   = '0;
                    state_d = S_FETCH;
                end
            end
            S_FETCH: begin
                // First cycle presents cfg_idx, second cycle captures the table word
                if (cnt_q == '0) begin
                    cnt_d = CNT_W'(1);
                end else begin
                    cnt_d     = '0;
                    wr_word_d = cfg_word;
                    tx_word_d = cfg_word;
                    rx_en_d   = 1'b0;
                    kind_d    = FR_WRITE;
                    go_d      = 1'b1;
                    state_d   = S_WR_SHIFT;
                end
            end
            S_WR_SHIFT, S_RD_CMD, S_RD_SHIFT: begin
                if (frame_done) begin
                    if (state_q == S_RD_SHIFT) begin
                        rd_data_d = rx_word;
                    end
                    cnt_d   = '0;
                    state_d = S_LATCH;
                end
            end
            S_LATCH: begin
                if (cnt_q == LE_LAST) begin
                    cnt_d = '0;
                    // The readback frame follows its command without a settle gap
                    if (kind_q == FR_RDCMD) begin
                        tx_word_d = '0;
                        rx_en_d   = 1'b1;
                        kind_d    = FR_READ;
                        go_d      = 1'b1;
                        state_d   = S_RD_SHIFT;
                    end else begin
                        state_d = S_GAP;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_GAP: begin
                if (cnt_q == GAP_LAST) begin
                    cnt_d = '0;
                    if (kind_q == FR_READ) begin
                        state_d = S_CHECK;
                    end else if (VERIFY != 0) begin
                        tx_word_d = '0;
                        tx_word_d[2*ADDR_W-1:0] = {wr_word_q[ADDR_W-1:0], RD_CMD_NIBBLE};
                        rx_en_d   = 1'b0;
                        kind_d    = FR_RDCMD;
                        go_d      = 1'b1;
                        state_d   = S_RD_CMD;
                    end else begin
                        state_d = S_NEXT;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_CHECK: begin
                // Address nibble is not part of the compared register contents
                if (rd_data_q[DATA_W-1:ADDR_W] == wr_word_q[DATA_W-1:ADDR_W]) begin
                    state_d = S_NEXT;
                end else if (retry_q < RETRY_LIM) begin
                    retry_d = retry_q + RETRY_W'(1);
                    cnt_d   = '0;
                    state_d = S_FETCH;
                end else begin
                    state_d = S_ERR;
                end
            end
            S_NEXT: begin
                retry_d = '0;
                if (idx_q == IDX_LAST) begin
                    state_d = S_DONE;
                end else begin
                    idx_d   = idx_q + IDX_W'(1);
                    cnt_d   = '0;
                    state_d = S_FETCH;
                end
            end
            S_DONE: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            S_ERR: begin
                error_d   = 1'b1;
                err_idx_d = idx_q;
                busy_d    = 1'b0;
                state_d   = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_spi_cfg_sequencer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_spi_cfg_sequencer
//  Description : Self-checking bench: three sequencer instances (write-only,
//                verify with retries, 24-bit fast clock) against an SPI device
//                model with a register file and injectable readback faults.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_cfg_sequencer;

    localparam int NI = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [2:0]  start_r = 3'b000;
    logic [2:0]  miso_r  = 3'b000;
    logic [2:0]  sclk_w, mosi_w, le_w, busy_w, done_w, err_w;
    logic [1:0]  idxA, idxB, eiA, eiB;
    logic [0:0]  idxC, eiC;
    logic [31:0] wordA, wordB, rdA, rdB;
    logic [23:0] wordC, rdC;
    logic [31:0] rdd [NI];
    int          eid [NI];

    logic [31:0] tab [NI][3];
    int          wid [NI] = '{32, 32, 24};

    assign rdd[0] = rdA;
    assign rdd[1] = rdB;
    assign rdd[2] = {8'h00, rdC};
    assign eid[0] = int'(eiA);
    assign eid[1] = int'(eiB);
    assign eid[2] = int'(eiC);

    // Table memory: word appears one clk after the index
    always @(posedge clk) begin
        wordA <= tab[0][idxA];
        wordB <= tab[1][idxB];
        wordC <= tab[2][idxC][23:0];
    end

    spi_cfg_sequencer #(.NUM_REGS(3), .DATA_W(32), .CLK_DIV(4), .LE_HOLD(4),
        .GAP_CYCLES(600), .VERIFY(0), .MAX_RETRY(2)) dut_a (
        .clk(clk), .rst(rst), .start(start_r[0]), .cfg_idx(idxA), .cfg_word(wordA),
        .spi_clk(sclk_w[0]), .spi_mosi(mosi_w[0]), .spi_miso(miso_r[0]), .spi_le(le_w[0]),
        .busy(busy_w[0]), .done(done_w[0]), .error(err_w[0]), .err_idx(eiA), .rd_data(rdA));

    spi_cfg_sequencer #(.NUM_REGS(3), .DATA_W(32), .CLK_DIV(4), .LE_HOLD(4),
        .GAP_CYCLES(100), .VERIFY(1), .MAX_RETRY(2)) dut_b (
        .clk(clk), .rst(rst), .start(start_r[1]), .cfg_idx(idxB), .cfg_word(wordB),
        .spi_clk(sclk_w[1]), .spi_mosi(mosi_w[1]), .spi_miso(miso_r[1]), .spi_le(le_w[1]),
        .busy(busy_w[1]), .done(done_w[1]), .error(err_w[1]), .err_idx(eiB), .rd_data(rdB));

    spi_cfg_sequencer #(.NUM_REGS(2), .DATA_W(24), .CLK_DIV(1), .LE_HOLD(2),
        .GAP_CYCLES(20), .VERIFY(0), .MAX_RETRY(2)) dut_c (
        .clk(clk), .rst(rst), .start(start_r[2]), .cfg_idx(idxC), .cfg_word(wordC),
        .spi_clk(sclk_w[2]), .spi_mosi(mosi_w[2]), .spi_miso(miso_r[2]), .spi_le(le_w[2]),
        .busy(busy_w[2]), .done(done_w[2]), .error(err_w[2]), .err_idx(eiC), .rd_data(rdC));

    // ---------------- SPI device model (one per instance) ----------------
    int          scen_id = 0;
    int          mode [NI] = '{0, 0, 0};   // 0 echo, 1 corrupt reg1 first read, 2 corrupt reg2 always
    int          cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [2:0]  prev_le = 3'b111;
    logic [2:0]  prev_sc = 3'b000;
    int          seen_scen [NI] = '{-1, -1, -1};
    int          cor_scen = -1;
    int          bitn [NI];
    logic [31:0] cap [NI];
    logic [31:0] rdw [NI];
    logic        pend_rd [NI] = '{1'b0, 1'b0, 1'b0};
    logic        in_rd [NI];
    logic [3:0]  rd_addr [NI];
    logic [31:0] regs [NI][16];
    int          nfr [NI] = '{0, 0, 0};
    logic [31:0] flog [NI][32];
    int          ftyp [NI][32];
    int          wcnt [NI][16];
    int          nshort [NI] = '{0, 0, 0};
    int          hi_run [NI] = '{0, 0, 0};
    int          min_gap [NI];
    int          last_rise [NI];
    int          rise_min [NI];
    int          rise_max [NI];

    always @(negedge clk) begin
        for (int k = 0; k < NI; k++) begin
            if (prev_le[k] && !le_w[k]) begin
                if (seen_scen[k] != scen_id) begin
                    seen_scen[k] = scen_id;
                    nfr[k]       = 0;
                    nshort[k]    = 0;
                    min_gap[k]   = 1 << 30;
                    rise_min[k]  = 1 << 30;
                    rise_max[k]  = 0;
                    pend_rd[k]   = 1'b0;
                    for (int a = 0; a < 16; a++) wcnt[k][a] = 0;
                end else if (nfr[k] > 0 && hi_run[k] < min_gap[k]) begin
                    min_gap[k] = hi_run[k];
                end
                bitn[k]      = 0;
                cap[k]       = 32'h0;
                in_rd[k]     = pend_rd[k];
                last_rise[k] = -1;
                rdw[k]       = 32'h0;
                if (pend_rd[k]) begin
                    rdw[k] = regs[k][rd_addr[k]];
                    if (mode[k] == 1 && rd_addr[k] == 4'd1 && cor_scen != scen_id) begin
                        rdw[k][20] = ~rdw[k][20];
                        cor_scen   = scen_id;
                    end
                    if (mode[k] == 2 && rd_addr[k] == 4'd2) begin
                        rdw[k][20] = ~rdw[k][20];
                    end
                end
                miso_r[k] = rdw[k][0];
            end
            if (!le_w[k] && sclk_w[k] && !prev_sc[k]) begin
                if (bitn[k] < 32) cap[k][bitn[k]] = mosi_w[k];
                bitn[k] = bitn[k] + 1;
                if (last_rise[k] >= 0) begin
                    if (cyc - last_rise[k] < rise_min[k]) rise_min[k] = cyc - last_rise[k];
                    if (cyc - last_rise[k] > rise_max[k]) rise_max[k] = cyc - last_rise[k];
                end
                last_rise[k] = cyc;
                miso_r[k] = (bitn[k] < 32) ? rdw[k][bitn[k]] : 1'b0;
            end
            if (!prev_le[k] && le_w[k]) begin
                hi_run[k] = 0;
                miso_r[k] = 1'b0;
                if (bitn[k] != wid[k]) begin
                    nshort[k] = nshort[k] + 1;
                end else begin
                    if (nfr[k] < 32) flog[k][nfr[k]] = cap[k];
                    if (in_rd[k]) begin
                        if (nfr[k] < 32) ftyp[k][nfr[k]] = 2;
                        pend_rd[k] = 1'b0;
                    end else if (cap[k][3:0] == 4'hE) begin
                        if (nfr[k] < 32) ftyp[k][nfr[k]] = 1;
                        pend_rd[k] = 1'b1;
                        rd_addr[k] = cap[k][7:4];
                    end else begin
                        if (nfr[k] < 32) ftyp[k][nfr[k]] = 0;
                        regs[k][cap[k][3:0]] = cap[k];
                        wcnt[k][cap[k][3:0]] = wcnt[k][cap[k][3:0]] + 1;
                    end
                    nfr[k] = nfr[k] + 1;
                end
            end else if (le_w[k]) begin
                hi_run[k] = hi_run[k] + 1;
            end
            prev_le[k] = le_w[k];
            prev_sc[k] = sclk_w[k];
        end
    end

    // ---------------- checking ----------------
    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total = total + 1;
        if (act !== exp) begin
            bad = bad + 1;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic pulse_start(input int k);
        @(negedge clk);
        start_r[k] = 1'b1;
        @(negedge clk);
        start_r[k] = 1'b0;
    endtask

    task automatic wait_end(input int k);
        int n;
        n = 0;
        while (!(done_w[k] || err_w[k]) && n < 20000) begin
            @(negedge clk);
            n++;
        end
        check("sequence_finished_in_time", 32'(n < 20000), 32'd1);
        repeat (3) @(negedge clk);
    endtask

    task automatic wait_frames(input int k, input int want);
        int n;
        n = 0;
        while (!(seen_scen[k] == scen_id && nfr[k] >= want && !le_w[k]) && n < 20000) begin
            @(negedge clk);
            n++;
        end
        check("frame_reached_in_time", 32'(n < 20000), 32'd1);
    endtask

    typedef struct {
        int          inst;
        int          mode;
        bit          exp_done;
        bit          exp_err;
        int          exp_eidx;
        int          exp_frames;
        int          exp_wr0;
        int          exp_wr1;
        int          exp_wr2;
        bit          chk_rd;
        logic [31:0] exp_rd;
        int          exp_period;
        int          min_gap_req;
    } vec_t;

    vec_t vt [5];

    initial begin
        int   k;
        int   a;
        logic [3:0] last_a;
        logic [31:0] w;
        logic [31:0] exp_w;

        tab[0] = '{32'h81400320, 32'h81400321, 32'h81400302};
        tab[1] = '{32'h81400320, 32'h81400321, 32'h81400302};
        tab[2] = '{32'h008140A0, 32'h005A3C71, 32'h00000000};

        //          inst mode done err eidx frames wr0 wr1 wr2 chk  rd            period gap
        vt[0] = '{0,   0,   1'b1, 1'b0, 0, 3,  1, 1, 1, 1'b0, 32'h0,        8, 600};
        vt[1] = '{1,   0,   1'b1, 1'b0, 0, 9,  1, 1, 1, 1'b1, 32'h81400302, 8, 0};
        vt[2] = '{1,   1,   1'b1, 1'b0, 0, 12, 1, 2, 1, 1'b1, 32'h81400302, 8, 0};
        vt[3] = '{1,   2,   1'b0, 1'b1, 2, 15, 1, 1, 3, 1'b1, 32'h81500302, 8, 0};
        vt[4] = '{2,   0,   1'b1, 1'b0, 0, 2,  1, 1, 0, 1'b0, 32'h0,        2, 20};

        // Reset values
        #23;
        for (int i = 0; i < NI; i++) begin
            check("reset_spi_clk", 32'(sclk_w[i]), 32'd0);
            check("reset_mosi",    32'(mosi_w[i]), 32'd0);
            check("reset_le",      32'(le_w[i]),   32'd1);
            check("reset_busy",    32'(busy_w[i]), 32'd0);
            check("reset_done",    32'(done_w[i]), 32'd0);
            check("reset_error",   32'(err_w[i]),  32'd0);
            check("reset_rd_data", rdd[i],         32'd0);
            check("reset_err_idx", 32'(eid[i]),    32'd0);
        end
        check("reset_cfg_idx", {28'd0, idxA, idxB}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Table-driven sequences
        for (int v = 0; v < 5; v++) begin
            k = vt[v].inst;
            scen_id = scen_id + 1;
            mode[k] = vt[v].mode;
            pulse_start(k);
            check("busy_after_start", 32'(busy_w[k]), 32'd1);
            wait_end(k);
            check("done",  32'(done_w[k]), 32'(vt[v].exp_done));
            check("error", 32'(err_w[k]),  32'(vt[v].exp_err));
            check("busy_at_end", 32'(busy_w[k]), 32'd0);
            if (vt[v].exp_err) check("err_idx", 32'(eid[k]), 32'(vt[v].exp_eidx));
            check("frame_count", 32'(nfr[k]), 32'(vt[v].exp_frames));
            check("short_frames", 32'(nshort[k]), 32'd0);
            check("writes_reg0", 32'(wcnt[k][0]), 32'(vt[v].exp_wr0));
            check("writes_reg1", 32'(wcnt[k][1]), 32'(vt[v].exp_wr1));
            check("writes_reg2", 32'(wcnt[k][2]), 32'(vt[v].exp_wr2));
            check("spi_clk_period_min", 32'(rise_min[k]), 32'(vt[v].exp_period));
            check("spi_clk_period_max", 32'(rise_max[k]), 32'(vt[v].exp_period));
            if (vt[v].min_gap_req > 0)
                check("gap_long_enough", 32'(min_gap[k] >= vt[v].min_gap_req), 32'd1);
            if (vt[v].chk_rd) check("rd_data", rdd[k], vt[v].exp_rd);
            last_a = 4'h0;
            for (int i = 0; i < nfr[k] && i < 32; i++) begin
                w = flog[k][i];
                if (ftyp[k][i] == 0) begin
                    a = int'(w[3:0]);
                    exp_w = (a < 3) ? tab[k][a] : 32'hDEADBEEF;
                    check("write_word", w, exp_w);
                    last_a = w[3:0];
                end else if (ftyp[k][i] == 1) begin
                    check("read_cmd_word", w, {24'h0, last_a, 4'hE});
                end else begin
                    check("read_frame_mosi", w, 32'h0);
                end
            end
        end

        // Reset in the middle of reg 1's write frame
        scen_id = scen_id + 1;
        mode[0] = 0;
        pulse_start(0);
        wait_frames(0, 1);
        repeat (40) @(negedge clk);
        check("mid_frame_le_low", 32'(le_w[0]), 32'd0);
        #3 rst = 1'b1;
        #1;
        check("abort_spi_clk", 32'(sclk_w[0]), 32'd0);
        check("abort_mosi",    32'(mosi_w[0]), 32'd0);
        check("abort_le",      32'(le_w[0]),   32'd1);
        check("abort_busy",    32'(busy_w[0]), 32'd0);
        check("abort_done",    32'(done_w[0]), 32'd0);
        check("abort_cfg_idx", 32'(idxA),      32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Fresh run after the abort, with a start pulse while busy
        scen_id = scen_id + 1;
        pulse_start(0);
        wait_frames(0, 1);
        check("busy_before_ignored_start", 32'(busy_w[0]), 32'd1);
        pulse_start(0);
        wait_end(0);
        check("rerun_done", 32'(done_w[0]), 32'd1);
        check("rerun_error", 32'(err_w[0]), 32'd0);
        check("rerun_frame_count", 32'(nfr[0]), 32'd3);
        check("rerun_first_word", flog[0][0], tab[0][0]);
        check("rerun_last_word", flog[0][2], tab[0][2]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/spi_cfg_sequencer.md
Name: spi_cfg_sequencer

Overview:
Parametrised SPI configuration sequencer for the board's clock and converter devices. It is the generalised successor of the fixed CDCE62005 loader.
- Walks an external register table of NUM_REGS words and shifts each word out LSB-first over a 3-wire+LE SPI port.
- Generates SPI clock internally from clk.
- Optionally reads each register back, compares it, and retries writes that fail the check.
- Sits between board bring-up control and the device; done/error feed the bring-up status register.

Parameters:
NUM_REGS, 11, number of table entries to write (1..256)
DATA_W, 32, SPI word width in bits (8..32, multiple of 4)
CLK_DIV, 4, spi_clk half-period in clk cycles (>=1)
LE_HOLD, 4, spi_le high cycles after each frame before the gap starts
GAP_CYCLES, 600, idle clk cycles between frames (device write settle)
VERIFY, 1, 1 = readback-compare each word after writing; 0 = write only
MAX_RETRY, 2, rewrites per word allowed after a compare mismatch

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
start  in  1  one-cycle pulse; begins a full sequence when idle
cfg_idx  out  clog2(NUM_REGS)  table index being fetched
cfg_word  in  DATA_W  table word for cfg_idx, valid 1 clk after cfg_idx changes; low nibble = device register address
spi_clk  out  1  SPI clock, idle low
spi_mosi  out  1  serial data out
spi_miso  in  1  serial data in
spi_le  out  1  latch enable, active low during a frame, idle high
busy  out  1  high from start acceptance until done or error
done  out  1  sticky; set when all words written (and verified); cleared by next start
error  out  1  sticky; set when a word exhausts its retries; cleared by next start
err_idx  out  clog2(NUM_REGS)  index of the failing word, valid while error=1
rd_data  out  DATA_W  last readback word

Behaviour:
- Reset values: spi_clk=0, spi_mosi=0, spi_le=1, busy=0, done=0, error=0, cfg_idx=0, err_idx=0, rd_data=0; state=IDLE.
- Reset mid-frame aborts immediately to the reset values. No partial-frame completion.
- start is ignored while busy. start in IDLE clears done/error, sets busy and idx=0, then goes to FETCH.
- FETCH (2 clk): drive cfg_idx, latch cfg_word into the shift register and the compare register, then go to WR_SHIFT.
- WR_SHIFT:
  - spi_le=0.
  - Each bit spans 2*CLK_DIV clks. mosi updates at the start of the bit with spi_clk low; spi_clk rises at mid-bit (device samples here); data shifts right.
  - After DATA_W bits, spi_clk=0 and go to LATCH.
- LATCH: spi_le=1 for LE_HOLD clks, then go to GAP.
- GAP: GAP_CYCLES clks. The next state is one of:
  - RD_CMD if VERIFY and the last frame was a write;
  - CHECK if the last frame was a read;
  - NEXT otherwise.
- RD_CMD: shift the read command {0..., addr[3:0], 4'hE} (addr = cfg_word[3:0]) with the same timing as WR_SHIFT, then LATCH, then RD_SHIFT.
- RD_SHIFT:
  - spi_le=0; DATA_W clocks with mosi=0.
  - miso is sampled on each spi_clk rising edge and shifted in at the MSB (right-shift), so the first bit lands in bit 0.
  - Then LATCH, GAP, CHECK.
- CHECK:
  - Compare rd_data[DATA_W-1:4] with the written word [DATA_W-1:4]; the address nibble is ignored.
  - Match: go to NEXT.
  - Mismatch with retry_cnt<MAX_RETRY: increment retry_cnt and go to FETCH for the same idx.
  - Mismatch otherwise: go to ERR.
- NEXT: retry_cnt=0.
  - If idx==NUM_REGS-1, go to DONE.
  - Otherwise increment idx and go to FETCH.
- DONE: done=1, busy=0, go to IDLE. ERR: error=1, err_idx=idx, busy=0, go to IDLE.
- Frame counters are sized for DATA_W, CLK_DIV and GAP_CYCLES with no overflow. Counters do not wrap within a frame.

Decomposition:
- Shared package spi_cfg_pkg holds:
  - the state enum;
  - the read-command nibble (4'hE);
  - the addr-field width of 4 bits;
  - a clog2 helper function.
- One sub-module, spi_frame_shifter, handles one DATA_W frame:
  - inputs: go, tx word, rx_en;
  - outputs: spi_clk, mosi, le, rx word, frame_done.
  - The sequencer FSM owns FETCH/GAP/CHECK/retry only.

Test Plan:
- NUM_REGS=3, VERIFY=0, table {81400320,81400321,81400302}: start -> 3 frames.
  - Bench SPI model captures each word LSB-first, matching the table exactly.
  - spi_le is low for exactly 32 bits per frame; gaps are >=600 clks; done=1, error=0.
- VERIFY=1, model echoes written register: each write is followed by read cmd 0x0000000E|addr<<4 and a readback frame; rd_data matches; done=1.
- VERIFY=1, model corrupts bit 20 of reg 1 on the first read only: reg 1 is written twice, the sequence completes, done=1.
- VERIFY=1, MAX_RETRY=2, model always corrupts reg 2: reg 2 is written 3 times, then error=1, err_idx=2, done=0, busy=0.
- rst asserted mid-WR_SHIFT of reg 1: all outputs take reset values the same cycle (async); a new start rewrites from index 0.
- start pulsed while busy: ignored, and the frame count is unchanged. Then DATA_W=24, CLK_DIV=1: spi_clk period is 2 clk and 24-bit frames are captured correctly.
